// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready commands and level, pulse and sweep modes.
// Sweep mode is present only when DECODER_SWEEP_EN is defined; otherwise mode 10 is rejected like 11.
`timescale 1ns/1ps
module onehot_decoder_seq #(
  parameter int SEL_W  = 3,
  parameter int OUT_W  = 8,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] hold,
  output logic [OUT_W-1:0]  out,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LEVEL, PULSE, SWEEP} state_t;

  state_t              state, state_nx;
  logic [OUT_W-1:0]    out_nx;
  logic                err_nx;
  logic [HOLD_W-1:0]   cnt, cnt_nx;
  logic                accept, in_ok, mode_ok;

`ifdef DECODER_SWEEP_EN
  localparam int POS_W = $clog2(OUT_W);
  logic [SEL_W-1:0]  idx, idx_nx;
  logic [HOLD_W-1:0] hold_r, hold_nx;
  logic [POS_W-1:0]  pos, pos_nx;
`endif

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    return OUT_W'(1) << i;
  endfunction

  // A full decode needs no range check; a partial one rejects indices past the last output.
  generate
    if (OUT_W >= (1 << SEL_W)) begin : g_full
      assign in_ok = 1'b1;
    end else begin : g_part
      assign in_ok = (in < SEL_W'(OUT_W));
    end
  endgenerate

  always_comb begin
    mode_ok = 1'b0;
    case (mode)
      2'b00, 2'b01: mode_ok = 1'b1;
`ifdef DECODER_SWEEP_EN
      2'b10:        mode_ok = 1'b1;
`endif
      default:      mode_ok = 1'b0;
    endcase
  end

  assign in_ready = (state == IDLE) || (state == LEVEL);
  assign busy     = (state == PULSE) || (state == SWEEP);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    out_nx   = out;
    err_nx   = 1'b0;
    cnt_nx   = cnt;
`ifdef DECODER_SWEEP_EN
    idx_nx   = idx;
    hold_nx  = hold_r;
    pos_nx   = pos;
`endif
    case (state)
      PULSE: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          out_nx   = '0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
`ifdef DECODER_SWEEP_EN
      // pos counts the positions still to visit after the current one.
      SWEEP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (pos == '0) begin
          state_nx = IDLE;
          out_nx   = '0;
        end else begin
          idx_nx = (idx == SEL_W'(OUT_W - 1)) ? '0 : idx + 1'b1;
          out_nx = onehot(idx_nx);
          cnt_nx = hold_r;
          pos_nx = pos - 1'b1;
        end
      end
`endif
      default: begin
        if (accept) begin
          if (!in_ok || !mode_ok) begin
            state_nx = IDLE;
            out_nx   = '0;
            err_nx   = 1'b1;
          end else begin
            out_nx = onehot(in);
            cnt_nx = hold;
            case (mode)
              2'b01: state_nx = PULSE;
`ifdef DECODER_SWEEP_EN
              2'b10: begin
                state_nx = SWEEP;
                idx_nx   = in;
                hold_nx  = hold;
                pos_nx   = POS_W'(OUT_W - 1);
              end
`endif
              default: state_nx = LEVEL;
            endcase
          end
        end
      end
    endcase
  end

  // Output is reset along with control so nothing is driven after an aborted pulse or sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      out    <= '0;
      err    <= 1'b0;
      cnt    <= '0;
`ifdef DECODER_SWEEP_EN
      idx    <= '0;
      hold_r <= '0;
      pos    <= '0;
`endif
    end else begin
      state  <= state_nx;
      out    <= out_nx;
      err    <= err_nx;
      cnt    <= cnt_nx;
`ifdef DECODER_SWEEP_EN
      idx    <= idx_nx;
      hold_r <= hold_nx;
      pos    <= pos_nx;
`endif
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: an 8-output instance for the main modes and a
// 6-output instance for range checking; sweep expectations follow DECODER_SWEEP_EN.
`timescale 1ns/1ps
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, v6;
  logic [2:0] in_s;
  logic [1:0] mode;
  logic [3:0] hold;
  logic       rdy8, busy8, err8;
  logic [7:0] out8;
  logic       rdy6, busy6, err6;
  logic [5:0] out6;
  int         checks   = 0;
  int         failures = 0;
  int         n;
  logic [7:0] exp8;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.SEL_W(3), .OUT_W(8), .HOLD_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in(in_s), .mode(mode), .hold(hold), .out(out8), .busy(busy8), .err(err8)
  );

  onehot_decoder_seq #(.SEL_W(3), .OUT_W(6), .HOLD_W(4)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6),
    .in(in_s), .mode(mode), .hold(hold), .out(out6), .busy(busy6), .err(err6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Presents one command, lets it be accepted, returns at the negedge of the first output cycle.
  task automatic send(input logic to6, input logic [2:0] i, input logic [1:0] m, input logic [3:0] h);
    @(negedge clk);
    in_s = i; mode = m; hold = h;
    if (to6) v6 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    v6       = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; v6 = 1'b0; in_s = '0; mode = '0; hold = '0;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_out", out8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_err", err8, 0);
    chk("rst_ready", rdy8, 1);
    @(negedge clk) rst_n = 1'b1;

    // Level mode held, then replaced without a gap
    send(0, 3'd5, 2'b00, 4'd0);
    chk("lvl_out", out8, 8'b0010_0000);
    chk("lvl_busy", busy8, 0);
    chk("lvl_ready", rdy8, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out8 == 8'b0010_0000) n++;
    end
    chk("lvl_held20", n, 20);
    send(0, 3'd2, 2'b00, 4'd0);
    chk("lvl_replace", out8, 8'b0000_0100);

    // Pulse hold=3, with an ignored command presented while busy
    send(0, 3'd3, 2'b01, 4'd3);
    for (int k = 0; k < 4; k++) begin
      chk("pulse_out", out8, 8'b0000_1000);
      chk("pulse_busy", busy8, 1);
      chk("pulse_ready", rdy8, 0);
      chk("pulse_noerr", err8, 0);
      if (k == 0) begin
        in_s = 3'd1; mode = 2'b00; in_valid = 1'b1;
      end
      if (k == 3) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("pulse_end_out", out8, 0);
    chk("pulse_end_busy", busy8, 0);
    chk("pulse_end_ready", rdy8, 1);
    @(negedge clk);
    chk("pulse_ignored", out8, 0);

    // Pulse hold=0: single cycle
    send(0, 3'd0, 2'b01, 4'd0);
    chk("p0_out", out8, 8'b0000_0001);
    @(negedge clk);
    chk("p0_end", out8, 0);

    // Pulse hold=15: maximum step, no counter wrap
    send(0, 3'd7, 2'b01, 4'd15);
    chk("pmax_first", out8, 8'b1000_0000);
    n = 0;
    for (int k = 0; k < 24; k++) begin
      if (out8 != 0) n++;
      @(negedge clk);
    end
    chk("pmax_len", n, 16);
    chk("pmax_idle", busy8, 0);

    // Sweep with wrap (or rejection when sweep is compiled out)
    send(0, 3'd6, 2'b10, 4'd1);
`ifdef DECODER_SWEEP_EN
    for (int k = 0; k < 16; k++) begin
      exp8 = 8'b1 << ((6 + k / 2) % 8);
      chk("sweep_out", out8, exp8);
      chk("sweep_busy", busy8, 1);
      @(negedge clk);
    end
    chk("sweep_end_out", out8, 0);
    chk("sweep_end_busy", busy8, 0);
`else
    chk("nosweep_out", out8, 0);
    chk("nosweep_err", err8, 1);
    chk("nosweep_busy", busy8, 0);
    @(negedge clk);
    chk("nosweep_errclr", err8, 0);
`endif

    // Reserved mode, from LEVEL
    send(0, 3'd4, 2'b00, 4'd0);
    chk("lvl4_out", out8, 8'b0001_0000);
    send(0, 3'd1, 2'b11, 4'd0);
    chk("rsv_out", out8, 0);
    chk("rsv_err", err8, 1);
    chk("rsv_ready", rdy8, 1);
    @(negedge clk);
    chk("rsv_errclr", err8, 0);

    // Range checking on the 6-output instance
    send(1, 3'd5, 2'b00, 4'd0);
    chk("r6_lvl5", out6, 6'b10_0000);
    send(1, 3'd7, 2'b00, 4'd0);
    chk("r6_oor_out", out6, 0);
    chk("r6_oor_err", err6, 1);
    @(negedge clk);
    chk("r6_oor_errclr", err6, 0);
    send(1, 3'd6, 2'b01, 4'd0);
    chk("r6_idx6_err", err6, 1);
    chk("r6_idx6_busy", busy6, 0);
    send(1, 3'd1, 2'b11, 4'd0);
    chk("r6_rsv_out", out6, 0);
    chk("r6_rsv_err", err6, 1);
    chk("r8_untouched", out8, 0);

    // Asynchronous reset in the middle of a long operation
`ifdef DECODER_SWEEP_EN
    send(0, 3'd4, 2'b10, 4'd3);
`else
    send(0, 3'd4, 2'b01, 4'd15);
`endif
    repeat (3) @(negedge clk);
    chk("ar_pre_busy", busy8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out", out8, 0);
    chk("ar_busy", busy8, 0);
    chk("ar_ready", rdy8, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_after_out", out8, 0);
    chk("ar_after_busy", busy8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
